// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage
// (core) and an external loader/debug requester (ext).
// Core normally wins; a 4-bit starvation counter forces an ext grant after
// STARVE_MAX consecutive core wins while ext waits. Ext reads return data one
// cycle later on ext_rvalid/ext_rdata.
// Optional feature: define DMEM_ARB_LOCK_EN to add ext_lock, which lets ext
// hold the port across consecutive cycles.
//
// Handshake: a request is performed in the cycle it is raised when granted
// (ext_gnt=1 or core_stall=0); an ungranted requester must keep its fields
// stable and retry next cycle. ext_rvalid is a one-cycle strobe, no backpressure.
module dmem_arbiter #(
   parameter int DWIDTH     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [DWIDTH-1:0] core_addr,
   input  logic [DWIDTH-1:0] core_wdata,
   output logic [DWIDTH-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [DWIDTH-1:0] ext_addr,
   input  logic [DWIDTH-1:0] ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
   input  logic              ext_lock,
`endif
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DWIDTH-1:0] ext_rdata,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              ext_rvalid_q, ext_rvalid_d;
   logic [DWIDTH-1:0] ext_rdata_q, ext_rdata_d;
   logic              starve_hit;
   logic              locked;
   logic              ext_win;
   logic              core_win;

`ifdef DMEM_ARB_LOCK_EN
   logic lock_q, lock_d;
   // Lock only holds while ext keeps both request and lock raised.
   assign locked = lock_q & ext_lock & ext_req;
`else
   assign locked = 1'b0;
`endif

   // Grant decision; gated by rst so nothing reaches dmem during reset.
   always_comb begin
      starve_hit = (starve_cnt_q >= STARVE_LIM);
      ext_win    = ext_req & (~core_req | starve_hit | locked) & ~rst;
      core_win   = core_req & ~ext_win & ~rst;
   end

   // Port mux toward dmem; idle port drives zeros.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ext_win) begin
         mem_we    = ext_we;
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
      end else if (core_win) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end
   end

   assign ext_gnt    = ext_win;
   assign core_stall = core_req & ~core_win & ~rst;
   assign core_rdata = mem_rdata;
   assign ext_rvalid = ext_rvalid_q;
   assign ext_rdata  = ext_rdata_q;

   // Next-state: starvation counter, ext read return path, optional lock.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!ext_req || ext_win) begin
         starve_cnt_d = 4'd0;
      end else if (core_win && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
      ext_rvalid_d = ext_win & ~ext_we;
      ext_rdata_d  = ext_rvalid_d ? mem_rdata : ext_rdata_q;
`ifdef DMEM_ARB_LOCK_EN
      lock_d = ext_win & ext_lock;
`endif
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= 4'd0;
         ext_rvalid_q <= 1'b0;
         ext_rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
         lock_q       <= 1'b0;
`endif
      end else begin
         starve_cnt_q <= starve_cnt_d;
         ext_rvalid_q <= ext_rvalid_d;
         ext_rdata_q  <= ext_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
         lock_q       <= lock_d;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small word-addressed
// memory model behind the dmem port. Lock scenario runs when DMEM_ARB_LOCK_EN
// is defined.
module tb_dmem_arbiter;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         core_req, core_we;
   logic [W-1:0] core_addr, core_wdata, core_rdata;
   logic         core_stall;
   logic         ext_req, ext_we;
   logic [W-1:0] ext_addr, ext_wdata;
   logic         ext_lock;
   logic         ext_gnt, ext_rvalid;
   logic [W-1:0] ext_rdata;
   logic         mem_we;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mem [0:63];

   dmem_arbiter #(.DWIDTH(W), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
`ifdef DMEM_ARB_LOCK_EN
      .ext_lock   (ext_lock),
`endif
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: asynchronous read, write on posedge
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic core_drv(input logic req, input logic we, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata);
      core_req   = req;
      core_we    = we;
      core_addr  = addr;
      core_wdata = wdata;
   endtask

   task automatic ext_drv(input logic req, input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata);
      ext_req   = req;
      ext_we    = we;
      ext_addr  = addr;
      ext_wdata = wdata;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      ext_lock = 1'b0;
      // Reset with both requesters active: outputs must stay quiet
      rst = 1'b1;
      core_drv(1'b1, 1'b1, 32'h10, 32'h1);
      ext_drv(1'b1, 1'b1, 32'h14, 32'h2);
      settle();
      chk("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("rst_rdata", ext_rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
      chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
      cyc();
      cyc();
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      settle();
      chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_wdata", mem_wdata, 32'd0);
      cyc();

      // Core store then load, ext idle
      core_drv(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      settle();
      chk("st_stall", {31'd0, core_stall}, 32'd0);
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_addr", mem_addr, 32'h10);
      chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      core_drv(1'b1, 1'b0, 32'h10, 32'h0);
      settle();
      chk("ld_stall", {31'd0, core_stall}, 32'd0);
      chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
      chk("ld_rdata", core_rdata, 32'hDEADBEEF);
      cyc();

      // Preload through the core port
      core_drv(1'b1, 1'b1, 32'h20, 32'h55);
      cyc();
      core_drv(1'b1, 1'b1, 32'h24, 32'h66);
      cyc();
      core_drv(1'b1, 1'b1, 32'h40, 32'h11);
      cyc();
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);

      // Back-to-back ext reads
      ext_drv(1'b1, 1'b0, 32'h20, 32'h0);
      settle();
      chk("rd0_gnt", {31'd0, ext_gnt}, 32'd1);
      chk("rd0_addr", mem_addr, 32'h20);
      chk("rd0_rvalid", {31'd0, ext_rvalid}, 32'd0);
      cyc();
      ext_drv(1'b1, 1'b0, 32'h24, 32'h0);
      settle();
      chk("rd1_rvalid", {31'd0, ext_rvalid}, 32'd1);
      chk("rd1_rdata", ext_rdata, 32'h55);
      cyc();
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      chk("rd2_rvalid", {31'd0, ext_rvalid}, 32'd1);
      chk("rd2_rdata", ext_rdata, 32'h66);
      cyc();
      settle();
      chk("rd3_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("rd3_hold", ext_rdata, 32'h66);

      // Ext write: no rvalid, data lands in memory
      ext_drv(1'b1, 1'b1, 32'h30, 32'h77);
      settle();
      chk("wr_gnt", {31'd0, ext_gnt}, 32'd1);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      cyc();
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      core_drv(1'b1, 1'b0, 32'h30, 32'h0);
      settle();
      chk("wr_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("wr_rdata_hold", ext_rdata, 32'h66);
      chk("wr_readback", core_rdata, 32'h77);
      cyc();

      // Starvation: both requesting continuously
      core_drv(1'b1, 1'b0, 32'h10, 32'h0);
      ext_drv(1'b1, 1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 10; i++) begin
         logic exp_ext;
         logic exp_rv;
         exp_ext = ((i % 5) == 4);
         exp_rv  = ((i % 5) == 0) && (i > 0);
         settle();
         chk($sformatf("stv%0d_gnt", i), {31'd0, ext_gnt}, {31'd0, exp_ext});
         chk($sformatf("stv%0d_stall", i), {31'd0, core_stall}, {31'd0, exp_ext});
         chk($sformatf("stv%0d_addr", i), mem_addr, exp_ext ? 32'h20 : 32'h10);
         chk($sformatf("stv%0d_rvalid", i), {31'd0, ext_rvalid}, {31'd0, exp_rv});
         if (exp_rv) chk($sformatf("stv%0d_rdata", i), ext_rdata, 32'h55);
         if (!exp_ext) chk($sformatf("stv%0d_core_rdata", i), core_rdata, 32'hDEADBEEF);
         cyc();
      end
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();

      // Build up starvation count of 2, then reset during an ext read grant
      core_drv(1'b1, 1'b0, 32'h10, 32'h0);
      ext_drv(1'b1, 1'b0, 32'h24, 32'h0);
      cyc();
      cyc();
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      ext_drv(1'b1, 1'b0, 32'h20, 32'h0);
      settle();
      chk("rr_gnt", {31'd0, ext_gnt}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rr_gnt_rst", {31'd0, ext_gnt}, 32'd0);
      chk("rr_mem_we_rst", {31'd0, mem_we}, 32'd0);
      chk("rr_rvalid_rst", {31'd0, ext_rvalid}, 32'd0);
      chk("rr_rdata_rst", ext_rdata, 32'd0);
      cyc();
      rst = 1'b0;
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      settle();
      chk("rr_rvalid_after", {31'd0, ext_rvalid}, 32'd0);
      chk("rr_rdata_after", ext_rdata, 32'd0);
      // Starvation count must have restarted from zero
      core_drv(1'b1, 1'b0, 32'h10, 32'h0);
      ext_drv(1'b1, 1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 5; i++) begin
         settle();
         chk($sformatf("rs%0d_gnt", i), {31'd0, ext_gnt}, {31'd0, (i == 4)});
         cyc();
      end
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();

      // Reset during an ext write grant: write abandoned
      ext_drv(1'b1, 1'b1, 32'h40, 32'h99);
      settle();
      chk("rw_mem_we", {31'd0, mem_we}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rw_mem_we_rst", {31'd0, mem_we}, 32'd0);
      cyc();
      rst = 1'b0;
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      core_drv(1'b1, 1'b0, 32'h40, 32'h0);
      settle();
      chk("rw_readback", core_rdata, 32'h11);
      cyc();
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();

`ifdef DMEM_ARB_LOCK_EN
      // Locked ext write burst holds off the core
      ext_lock = 1'b1;
      ext_drv(1'b1, 1'b1, 32'h44, 32'hA0);
      settle();
      chk("lk_first_gnt", {31'd0, ext_gnt}, 32'd1);
      cyc();
      core_drv(1'b1, 1'b0, 32'h10, 32'h0);
      for (int i = 0; i < 3; i++) begin
         ext_wdata = 32'hA1 + 32'(i);
         settle();
         chk($sformatf("lk%0d_gnt", i), {31'd0, ext_gnt}, 32'd1);
         chk($sformatf("lk%0d_stall", i), {31'd0, core_stall}, 32'd1);
         cyc();
      end
      ext_lock = 1'b0;
      settle();
      chk("lk_release_stall", {31'd0, core_stall}, 32'd0);
      chk("lk_release_gnt", {31'd0, ext_gnt}, 32'd0);
      cyc();
      core_drv(1'b0, 1'b0, 32'h0, 32'h0);
      ext_drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
